calc_mp_engine: RTL and testbench
=================================

// Module: calc_mp_engine
// PURPOSE
// - Parametrised successor of the four-port calculator DUT that sits under the wrapper and is driven through tb_if.
// - N tagged request ports, each with a two-cycle command/operand capture FSM feeding a per-port request FIFO.
// - Round-robin arbiter issues one request per cycle to a shared registered ALU.
// - Responses are routed back to the originating port with the original tag. Out-of-order completion across ports is legal.
// PARAMETERS
// NUM_PORTS   4   number of request/response channels (>=2)
// DATA_W      32  operand/result width
// TAG_W       2   request tag width, echoed on response
// FIFO_DEPTH  4   per-port request FIFO entries (power of 2, >=2)
// PORTS
// clk        in   1                    system clock, rising edge
// reset      in   1                    synchronous, active-high
// req_cmd    in   [NUM_PORTS][4]       command; non-zero marks cycle 1 of a request
// req_data   in   [NUM_PORTS][DATA_W]  op1 in the cmd cycle, op2 in the following cycle
// req_tag    in   [NUM_PORTS][TAG_W]   sampled in the cmd cycle
// req_ready  out  [NUM_PORTS]          port may start a request this cycle
// out_resp   out  [NUM_PORTS][2]       0 none, 1 ok, 2 overflow/underflow, 3 invalid cmd
// out_data   out  [NUM_PORTS][DATA_W]  result; 0 unless out_resp==1
// out_tag    out  [NUM_PORTS][TAG_W]   tag of the completing request
// BEHAVIOUR
// - Reset: all outputs 0, including req_ready. FIFOs emptied. FSMs to IDLE. RR pointer to port 0. ALU stage invalid.
//   req_ready rises in the first cycle after reset deasserts.
// - Reset mid-operation: every captured and in-flight request is dropped. No response is ever produced for it.
// - Capture FSM per port, IDLE->OP2->IDLE:
//   - IDLE with req_cmd!=0 and req_ready=1: latch cmd, tag and op1; go to OP2.
//   - OP2: latch op2 and push {cmd,tag,op1,op2} at the clock edge; back to IDLE.
//   - A command presented while req_ready=0 is ignored silently.
//   - req_cmd is don't-care in OP2.
// - req_ready[p] = (state==IDLE) && (fifo_count[p] < FIFO_DEPTH). It is low during OP2.
//   Back-to-back requests on one port therefore need 2 cycles each.
// - Arbiter:
//   - Grants the first non-empty FIFO starting at rr_ptr, in ascending order with wrap from NUM_PORTS-1 to 0.
//   - On a grant, rr_ptr = granted+1 mod NUM_PORTS. No grant means rr_ptr is unchanged.
//   - At most one pop per cycle.
// - A push and a pop on the same FIFO in the same cycle are legal: count is unchanged and data order is preserved.
// - ALU, registered, one cycle. cmd encodings:
//   - 1 ADD: carry out -> resp 2.
//   - 2 SUB: op2>op1 unsigned -> resp 2.
//   - 5 SHL / 6 SHR: logical shift by op2[$clog2(DATA_W)-1:0]; upper bits of op2 are ignored; always resp 1.
//   - Any other non-zero cmd: resp 3.
//   - Result arithmetic is modulo 2^DATA_W; data is forced to 0 on resp 2 or 3.
// - Output:
//   - out_* for the granted port are valid for exactly one cycle. All other ports show resp 0, data 0, tag 0.
//   - Outputs return to 0 in the next cycle unless another completion is due.
// - Latency: request cmd at cycle t, with its FIFO empty and the port winning arbitration, gives out_resp at t+3.
//   - Each extra queued or competing request adds 1 cycle.
// - Per port, responses come back in issue order.
// - Tags are echoed unchecked; duplicate tags are the requester's responsibility.
// STRUCTURE
// - calc_pkg: cmd_e (NOP=0, ADD=1, SUB=2, SHL=5, SHR=6), resp_e (NONE, OK, ERR, INV),
//   parametrised req_t struct {cmd, tag, op1, op2}.
// - Sub-module calc_req_fifo (sync FIFO, DEPTH/WIDTH params, count output), one instance per port via generate.
// - FSMs, arbiter and ALU stay inline in calc_mp_engine.
// TESTING
// - Reset held 3 cycles mid-request on port 2 -> no response on any port. All outputs 0 during reset. req_ready=4'hF 1 cycle after release.
// - Port 0: ADD 5+7 tag 1 at t -> out_resp[0]=1, out_data[0]=12, out_tag[0]=1 exactly at t+3.
// - Port 1: ADD FFFF_FFFF+1 -> resp 2, data 0. SUB 3-4 -> resp 2. cmd 4 -> resp 3. SHL 1 by 0x21 -> resp 1, data 2.
// - All 4 ports issue ADD in the same cycle t -> completions in port order 0,1,2,3 at t+3..t+6, each one cycle wide.
// - Port 3 streams requests with no pops possible -> req_ready[3] low after 4 pushes; a cmd presented while low gives no response.
// - Ports 0 and 2 saturated -> grants alternate 0,2,0,2; port 1 single request inserted -> served within NUM_PORTS cycles.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types for the multi-port calculator engine: command and response encodings.
package calc_pkg;

    localparam int unsigned CMD_W  = 4;
    localparam int unsigned RESP_W = 2;

    typedef enum logic [CMD_W-1:0] {
        CmdNop = 4'd0,
        CmdAdd = 4'd1,
        CmdSub = 4'd2,
        CmdShl = 4'd5,
        CmdShr = 4'd6
    } cmd_e;

    typedef enum logic [RESP_W-1:0] {
        RespNone = 2'd0,
        RespOk   = 2'd1,
        RespErr  = 2'd2,
        RespInv  = 2'd3
    } resp_e;

endpackage

// File: rtl/calc_req_fifo.sv
// Synchronous request FIFO with occupancy count; simultaneous push and pop keeps count and order.
module calc_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

    // Pointer and occupancy next-state.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/calc_mp_engine.sv
// N-port tagged calculator: per-port two-cycle capture into a FIFO, round-robin issue to a
// shared one-cycle registered ALU, response steered back to the requesting port.
module calc_mp_engine
    import calc_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned TAG_W      = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_PORTS-1:0][CMD_W-1:0]      req_cmd,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]     req_data,
    input  logic [NUM_PORTS-1:0][TAG_W-1:0]      req_tag,
    output logic [NUM_PORTS-1:0]                 req_ready,
    output logic [NUM_PORTS-1:0][RESP_W-1:0]     out_resp,
    output logic [NUM_PORTS-1:0][DATA_W-1:0]     out_data,
    output logic [NUM_PORTS-1:0][TAG_W-1:0]      out_tag
);

    localparam int unsigned PTR_W = $clog2(NUM_PORTS);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SH_W  = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
    } req_t;

    localparam int unsigned REQ_W = $bits(req_t);

    typedef enum logic [0:0] {StIdle, StOp2} cap_state_e;

    logic                             ready_en_q;
    logic [NUM_PORTS-1:0]             fifo_push, fifo_pop, fifo_empty;
    logic [NUM_PORTS-1:0][REQ_W-1:0]  fifo_wdata, fifo_rdata;
    logic [NUM_PORTS-1:0][CNT_W-1:0]  fifo_count;

    logic [PTR_W-1:0]  rr_q, rr_d;
    logic [PTR_W-1:0]  gnt_idx;
    logic              gnt_valid;
    logic [PTR_W:0]    scan_idx;
    req_t              gnt_req;

    logic              alu_valid_q, alu_valid_d;
    logic [PTR_W-1:0]  alu_port_q, alu_port_d;
    resp_e             alu_resp_q, alu_resp_d;
    logic [DATA_W-1:0] alu_data_q, alu_data_d;
    logic [TAG_W-1:0]  alu_tag_q, alu_tag_d;
    logic [DATA_W:0]   add_sum;

    // Holds req_ready low through reset and releases it one cycle after reset drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        cap_state_e        state_q, state_d;
        logic [CMD_W-1:0]  cmd_q, cmd_d;
        logic [TAG_W-1:0]  tag_q, tag_d;
        logic [DATA_W-1:0] op1_q, op1_d;
        logic              accept;
        logic              hit;
        req_t              push_req;

        assign req_ready[p] = ready_en_q && (state_q == StIdle) && (fifo_count[p] < DEPTH_CNT);
        assign accept       = req_ready[p] && (req_cmd[p] != '0);

        // Capture FSM: latch cmd/tag/op1 in IDLE, push with op2 in the following cycle.
        always_comb begin
            state_d = state_q;
            cmd_d   = cmd_q;
            tag_d   = tag_q;
            op1_d   = op1_q;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_d = StOp2;
                        cmd_d   = req_cmd[p];
                        tag_d   = req_tag[p];
                        op1_d   = req_data[p];
                    end
                end
                StOp2:   state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end

        // Capture FSM registers.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= StIdle;
                cmd_q   <= '0;
                tag_q   <= '0;
                op1_q   <= '0;
            end else begin
                state_q <= state_d;
                cmd_q   <= cmd_d;
                tag_q   <= tag_d;
                op1_q   <= op1_d;
            end
        end

        assign push_req      = '{cmd: cmd_q, tag: tag_q, op1: op1_q, op2: req_data[p]};
        assign fifo_push[p]  = (state_q == StOp2);
        assign fifo_wdata[p] = push_req;

        calc_req_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (REQ_W)
        ) u_fifo (
            .clk_i   (clk),
            .rst_i   (reset),
            .push_i  (fifo_push[p]),
            .wdata_i (fifo_wdata[p]),
            .pop_i   (fifo_pop[p]),
            .rdata_o (fifo_rdata[p]),
            .empty_o (fifo_empty[p]),
            .count_o (fifo_count[p])
        );

        assign hit         = alu_valid_q && (alu_port_q == PTR_W'(p));
        assign out_resp[p] = hit ? alu_resp_q : RespNone;
        assign out_data[p] = hit ? alu_data_q : '0;
        assign out_tag[p]  = hit ? alu_tag_q : '0;
    end

    // Round-robin arbiter: first non-empty FIFO at or after rr_q, wrapping at NUM_PORTS.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = rr_q;
        scan_idx  = '0;
        fifo_pop  = '0;
        rr_d      = rr_q;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            scan_idx = {1'b0, rr_q} + (PTR_W + 1)'(i);
            if (scan_idx >= (PTR_W + 1)'(NUM_PORTS)) begin
                scan_idx = scan_idx - (PTR_W + 1)'(NUM_PORTS);
            end
            if (!gnt_valid && !fifo_empty[scan_idx[PTR_W-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = scan_idx[PTR_W-1:0];
            end
        end
        if (gnt_valid) begin
            fifo_pop[gnt_idx] = 1'b1;
            rr_d = (gnt_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign gnt_req = req_t'(fifo_rdata[gnt_idx]);

    // ALU next-state for the granted request; error responses carry zero data.
    always_comb begin
        add_sum     = {1'b0, gnt_req.op1} + {1'b0, gnt_req.op2};
        alu_valid_d = gnt_valid;
        alu_port_d  = gnt_idx;
        alu_tag_d   = gnt_req.tag;
        alu_resp_d  = RespOk;
        alu_data_d  = '0;
        case (cmd_e'(gnt_req.cmd))
            CmdAdd: begin
                if (add_sum[DATA_W]) begin
                    alu_resp_d = RespErr;
                end else begin
                    alu_data_d = add_sum[DATA_W-1:0];
                end
            end
            CmdSub: begin
                if (gnt_req.op2 > gnt_req.op1) begin
                    alu_resp_d = RespErr;
                end else begin
                    alu_data_d = gnt_req.op1 - gnt_req.op2;
                end
            end
            CmdShl:  alu_data_d = gnt_req.op1 << gnt_req.op2[SH_W-1:0];
            CmdShr:  alu_data_d = gnt_req.op1 >> gnt_req.op2[SH_W-1:0];
            default: alu_resp_d = RespInv;
        endcase
        if (!gnt_valid) begin
            alu_resp_d = RespNone;
            alu_data_d = '0;
            alu_tag_d  = '0;
        end
    end

    // Arbiter pointer and ALU result stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q        <= '0;
            alu_valid_q <= 1'b0;
            alu_port_q  <= '0;
            alu_resp_q  <= RespNone;
            alu_data_q  <= '0;
            alu_tag_q   <= '0;
        end else begin
            rr_q        <= rr_d;
            alu_valid_q <= alu_valid_d;
            alu_port_q  <= alu_port_d;
            alu_resp_q  <= alu_resp_d;
            alu_data_q  <= alu_data_d;
            alu_tag_q   <= alu_tag_d;
        end
    end

endmodule

// File: tb/tb_calc_mp_engine.sv
// Directed bench for calc_mp_engine: reset behaviour, ALU encodings, latency, arbitration, backpressure.
module tb_calc_mp_engine;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int TW = 2;
    localparam int FD = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NP-1:0][3:0]    req_cmd;
    logic [NP-1:0][DW-1:0] req_data;
    logic [NP-1:0][TW-1:0] req_tag;
    logic [NP-1:0]         req_ready;
    logic [NP-1:0][1:0]    out_resp;
    logic [NP-1:0][DW-1:0] out_data;
    logic [NP-1:0][TW-1:0] out_tag;

    int checks = 0;
    int errors = 0;
    int rsp_cnt [NP];
    bit chk_seq = 1'b0;

    // Expected responding port in cycles 3..13 of the saturation scenario.
    int sat_port [11] = '{0, 2, 0, 2, 0, 2, 0, 1, 2, 0, 2};
    // Expected accepted requests per port in the streaming scenario.
    int stream_cnt [NP] = '{7, 7, 6, 6};

    // Port-1 ALU vectors: cmd, op1, op2, tag, resp, data.
    logic [3:0]    v_cmd  [8] = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd2, 4'd6, 4'd1, 4'd6};
    logic [DW-1:0] v_op1  [8] = '{32'hFFFF_FFFF, 32'd3, 32'd9, 32'd1, 32'd10,
                                  32'h8000_0000, 32'h7FFF_FFFF, 32'hF0};
    logic [DW-1:0] v_op2  [8] = '{32'd1, 32'd4, 32'd9, 32'h21, 32'd3, 32'd31, 32'd1, 32'h24};
    logic [TW-1:0] v_tag  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0]    v_resp [8] = '{2'd2, 2'd2, 2'd3, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
    logic [DW-1:0] v_data [8] = '{32'd0, 32'd0, 32'd0, 32'd2, 32'd7, 32'd1,
                                  32'h8000_0000, 32'hF};

    calc_mp_engine #(
        .NUM_PORTS  (NP),
        .DATA_W     (DW),
        .TAG_W      (TW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_cmd   (req_cmd),
        .req_data  (req_data),
        .req_tag   (req_tag),
        .req_ready (req_ready),
        .out_resp  (out_resp),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic clear_rsp();
        for (int p = 0; p < NP; p++) rsp_cnt[p] = 0;
    endtask

    // Advance one cycle, sample just after the edge and log any responses.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (out_resp[p] != 2'd0) begin
                if (chk_seq) begin
                    check("seq_data", 64'(out_data[p]), 64'(p * 100 + rsp_cnt[p]));
                    check("seq_tag", 64'(out_tag[p]), 64'(rsp_cnt[p] % 4));
                end
                rsp_cnt[p]++;
            end
        end
    endtask

    task automatic idle_inputs();
        req_cmd  = '0;
        req_data = '0;
        req_tag  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Drive a request on one port; returns in the cycle two after the cmd cycle.
    task automatic issue(input int p, input logic [3:0] cmd, input logic [TW-1:0] tag,
                         input logic [DW-1:0] op1, input logic [DW-1:0] op2);
        req_cmd[p]  = cmd;
        req_tag[p]  = tag;
        req_data[p] = op1;
        tick();
        req_cmd[p]  = 4'd0;
        req_tag[p]  = '0;
        req_data[p] = op2;
        tick();
        req_data[p] = '0;
    endtask

    task automatic check_one(input string name, input int p, input logic [1:0] resp,
                             input logic [DW-1:0] data, input logic [TW-1:0] tag);
        check({name, "_resp"}, 64'(out_resp), 64'(resp) << (2 * p));
        check({name, "_data"}, 64'(out_data[p]), 64'(data));
        check({name, "_tag"}, 64'(out_tag[p]), 64'(tag));
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        clear_rsp();

        // Reset state.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ready", 64'(req_ready), 64'd0);
            check("rst_resp", 64'(out_resp), 64'd0);
            check("rst_data", 64'(out_data), 64'd0);
            check("rst_tag", 64'(out_tag), 64'd0);
        end
        reset = 1'b0;
        tick();
        check("rel_ready", 64'(req_ready), 64'hF);

        // Request on port 2 queued, then reset for 3 cycles: it must vanish.
        clear_rsp();
        issue(2, 4'd1, 2'd2, 32'd11, 32'd22);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_resp", 64'(out_resp), 64'd0);
            check("midrst_ready", 64'(req_ready), 64'd0);
        end
        reset = 1'b0;
        tick();
        check("midrst_rel_ready", 64'(req_ready), 64'hF);
        repeat (8) tick();
        check("midrst_no_rsp", 64'(rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3]), 64'd0);

        // Port 0 ADD latency: response exactly at t+3, one cycle wide.
        issue(0, 4'd1, 2'd1, 32'd5, 32'd7);
        check("add_early", 64'(out_resp), 64'd0);
        tick();
        check_one("add0", 0, 2'd1, 32'd12, 2'd1);
        tick();
        check("add_after", 64'(out_resp), 64'd0);

        // Port 1 ALU encodings and error cases.
        for (int i = 0; i < 8; i++) begin
            issue(1, v_cmd[i], v_tag[i], v_op1[i], v_op2[i]);
            tick();
            check_one("alu1", 1, v_resp[i], v_data[i], v_tag[i]);
        end

        // All ports issue in the same cycle: completions in port order.
        do_reset();
        for (int p = 0; p < NP; p++) begin
            req_cmd[p]  = 4'd1;
            req_tag[p]  = 2'(p);
            req_data[p] = 32'(10 * (p + 1));
        end
        tick();
        for (int p = 0; p < NP; p++) begin
            req_cmd[p]  = 4'd0;
            req_tag[p]  = '0;
            req_data[p] = 32'd1;
        end
        tick();
        idle_inputs();
        check("all4_early", 64'(out_resp), 64'd0);
        for (int p = 0; p < NP; p++) begin
            tick();
            check_one("all4", p, 2'd1, 32'(10 * (p + 1) + 1), 2'(p));
        end
        tick();
        check("all4_after", 64'(out_resp), 64'd0);

        // All ports stream: ports 2 and 3 fill up and drop the cycle-12 command.
        do_reset();
        clear_rsp();
        chk_seq = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c == 10) check("stream_ready10", 64'(req_ready), 64'hF);
            if (c == 11) check("stream_ready11", 64'(req_ready), 64'h0);
            if (c == 12) check("stream_ready12", 64'(req_ready), 64'h3);
            for (int p = 0; p < NP; p++) begin
                if (c % 2 == 0) begin
                    req_cmd[p]  = 4'd1;
                    req_tag[p]  = 2'((c / 2) % 4);
                    req_data[p] = 32'(p * 100 + c / 2);
                end else begin
                    req_cmd[p]  = 4'd0;
                    req_tag[p]  = '0;
                    req_data[p] = '0;
                end
            end
            tick();
        end
        idle_inputs();
        repeat (40) tick();
        chk_seq = 1'b0;
        for (int p = 0; p < NP; p++) begin
            check("stream_count", 64'(rsp_cnt[p]), 64'(stream_cnt[p]));
        end

        // Ports 0 and 2 saturated, single port-1 request inserted at cycle 6.
        do_reset();
        for (int c = 0; c < 14; c++) begin
            if (c >= 3) begin
                check("sat_grant", 64'(out_resp), 64'd1 << (2 * sat_port[c - 3]));
            end
            if (c == 10) begin
                check("sat_p1_data", 64'(out_data[1]), 64'd77);
                check("sat_p1_tag", 64'(out_tag[1]), 64'd3);
            end
            idle_inputs();
            if (c % 2 == 0) begin
                req_cmd[0]  = 4'd1;
                req_data[0] = 32'(c);
                req_cmd[2]  = 4'd1;
                req_data[2] = 32'(200 + c);
                if (c == 6) begin
                    req_cmd[1]  = 4'd1;
                    req_tag[1]  = 2'd3;
                    req_data[1] = 32'd77;
                end
            end
            tick();
        end
        idle_inputs();
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
